// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational 32-bit ALU between two valid/ready requesters.
//   Round-robin arbitration picks one request per cycle. The chosen operation's
//   result is registered and presented on a single valid/ready result channel,
//   tagged with the port that issued it. Each port has a saturating grant counter.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   p0_* / p1_*             requester channels: valid/ready, operands a/b, aluop
//   res_valid/res_ready     result channel handshake
//   res_port, res_s         originating port and ALU result of the held result
//   res_zero                held result equals zero
//   gnt_cnt0, gnt_cnt1      saturating per-port grant counters (CNT_W bits)
module alu_share_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_valid,
    output logic             p0_ready,
    input  logic [31:0]      p0_a,
    input  logic [31:0]      p0_b,
    input  logic [3:0]       p0_aluop,
    input  logic             p1_valid,
    output logic             p1_ready,
    input  logic [31:0]      p1_a,
    input  logic [31:0]      p1_b,
    input  logic [3:0]       p1_aluop,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_port,
    output logic [31:0]      res_s,
    output logic             res_zero,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    logic             res_valid_q, res_valid_d;
    logic             res_port_q, res_port_d;
    logic [31:0]      res_s_q, res_s_d;
    logic             res_zero_q, res_zero_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic        slot_free;
    logic        grant_valid;
    logic        grant_port;
    logic [31:0] op_a, op_b;
    logic [3:0]  op_code;
    logic [31:0] alu_res;

    // The result register can take a new value if it is empty or drains this cycle.
    assign slot_free = !res_valid_q || res_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        if (slot_free) begin
            if (p0_valid && p1_valid) begin
                grant_valid = 1'b1;
                grant_port  = ~last_grant_q;
            end else if (p0_valid) begin
                grant_valid = 1'b1;
                grant_port  = 1'b0;
            end else if (p1_valid) begin
                grant_valid = 1'b1;
                grant_port  = 1'b1;
            end
        end
    end

    assign p0_ready = grant_valid && !grant_port;
    assign p1_ready = grant_valid && grant_port;

    // Operand mux feeding the single shared ALU.
    assign op_a    = grant_port ? p1_a     : p0_a;
    assign op_b    = grant_port ? p1_b     : p0_b;
    assign op_code = grant_port ? p1_aluop : p0_aluop;

    always_comb begin
        alu_res = 32'h0;
        case (op_code)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = {31'h0, ($signed(op_a) < $signed(op_b))};
            4'b1100: alu_res = ~(op_a | op_b);
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_port_d   = res_port_q;
        res_s_d      = res_s_q;
        res_zero_d   = res_zero_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (grant_valid) begin
            res_valid_d  = 1'b1;
            res_s_d      = alu_res;
            res_zero_d   = (alu_res == 32'h0);
            res_port_d   = grant_port;
            last_grant_d = grant_port;
            if (!grant_port && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
            if (grant_port && (cnt1_q != '1))  cnt1_d = cnt1_q + CNT_W'(1);
        end else if (slot_free) begin
            // Result drained (or never there) and nothing new: payload keeps old value.
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q  <= 1'b0;
            res_port_q   <= 1'b0;
            res_s_q      <= 32'h0;
            res_zero_q   <= 1'b0;
            last_grant_q <= 1'b1;  // port 0 wins the first contention
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_port_q   <= res_port_d;
            res_s_q      <= res_s_d;
            res_zero_q   <= res_zero_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_port  = res_port_q;
    assign res_s     = res_s_q;
    assign res_zero  = res_zero_q;
    assign gnt_cnt0  = cnt0_q;
    assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p1_valid, res_ready;
    logic [31:0] p0_a, p0_b, p1_a, p1_b;
    logic [3:0]  p0_aluop, p1_aluop;

    logic        p0_ready, p1_ready, res_valid, res_port, res_zero;
    logic [31:0] res_s;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    logic        s_p0_ready, s_p1_ready, s_res_valid, s_res_port, s_res_zero;
    logic [31:0] s_res_s;
    logic [1:0]  s_cnt0, s_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_a(p0_a), .p0_b(p0_b),
        .p0_aluop(p0_aluop),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_a(p1_a), .p1_b(p1_b),
        .p1_aluop(p1_aluop),
        .res_valid(res_valid), .res_ready(res_ready), .res_port(res_port),
        .res_s(res_s), .res_zero(res_zero),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    // Narrow-counter instance shares all stimulus; used for saturation.
    alu_share_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(s_p0_ready), .p0_a(p0_a), .p0_b(p0_b),
        .p0_aluop(p0_aluop),
        .p1_valid(p1_valid), .p1_ready(s_p1_ready), .p1_a(p1_a), .p1_b(p1_b),
        .p1_aluop(p1_aluop),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_port(s_res_port),
        .res_s(s_res_s), .res_zero(s_res_zero),
        .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++;
            $display("FAIL reset_valid got %b want 0", res_valid); end
        n_cmp++; if (res_s !== 32'h0) begin n_bad++;
            $display("FAIL reset_s got %h want 0", res_s); end
        n_cmp++; if (res_zero !== 1'b0 || res_port !== 1'b0) begin n_bad++;
            $display("FAIL reset_zero_port got %b%b want 00", res_zero, res_port); end
        n_cmp++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin n_bad++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1); end
    endtask

    task automatic test_single();
        p0_valid = 1'b1; p0_a = 32'd5; p0_b = 32'd7; p0_aluop = 4'b0010;
        p1_valid = 1'b0; res_ready = 1'b1;
        #1;
        n_cmp++; if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin n_bad++;
            $display("FAIL single_ready got %b%b want 10", p0_ready, p1_ready); end
        step();
        p0_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b1 || res_s !== 32'd12) begin n_bad++;
            $display("FAIL single_res got v=%b s=%0d want v=1 s=12", res_valid, res_s); end
        n_cmp++; if (res_port !== 1'b0 || res_zero !== 1'b0) begin n_bad++;
            $display("FAIL single_tag got port=%b zero=%b want 0 0", res_port, res_zero); end
        n_cmp++; if (gnt_cnt0 !== 16'd1) begin n_bad++;
            $display("FAIL single_cnt got %0d want 1", gnt_cnt0); end
    endtask

    task automatic test_alternate();
        logic        exp_p;
        logic [31:0] exp_s;
        reset = 1'b1;
        step();
        reset = 1'b0;
        p0_valid = 1'b1; p0_a = 32'd9; p0_b = 32'd9; p0_aluop = 4'b0110;
        p1_valid = 1'b1; p1_a = 32'hFFFF_FFFF; p1_b = 32'd1; p1_aluop = 4'b0111;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_p = (i % 2 == 1);
            exp_s = exp_p ? 32'd1 : 32'd0;
            #1;
            n_cmp++; if (p0_ready !== !exp_p || p1_ready !== exp_p) begin n_bad++;
                $display("FAIL alt_ready[%0d] got %b%b want %b%b", i, p0_ready, p1_ready,
                         !exp_p, exp_p); end
            step();
            n_cmp++; if (res_port !== exp_p || res_s !== exp_s || res_zero !== !exp_p)
            begin n_bad++;
                $display("FAIL alt_res[%0d] got port=%b s=%h z=%b want %b %h %b", i,
                         res_port, res_s, res_zero, exp_p, exp_s, !exp_p); end
        end
        n_cmp++; if (gnt_cnt0 !== 16'd2 || gnt_cnt1 !== 16'd2) begin n_bad++;
            $display("FAIL alt_cnt got %0d/%0d want 2/2", gnt_cnt0, gnt_cnt1); end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin n_bad++;
                $display("FAIL bp_ready[%0d] got %b%b want 00", i, p0_ready, p1_ready); end
            step();
            n_cmp++; if (res_valid !== 1'b1 || res_s !== 32'd1 || res_port !== 1'b1 ||
                         res_zero !== 1'b0) begin n_bad++;
                $display("FAIL bp_hold[%0d] got v=%b s=%h port=%b z=%b want 1 1 1 0", i,
                         res_valid, res_s, res_port, res_zero); end
            n_cmp++; if (gnt_cnt0 !== 16'd2 || gnt_cnt1 !== 16'd2) begin n_bad++;
                $display("FAIL bp_cnt[%0d] got %0d/%0d want 2/2", i, gnt_cnt0, gnt_cnt1); end
        end
        res_ready = 1'b1;
        #1;
        n_cmp++; if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin n_bad++;
            $display("FAIL bp_release got %b%b want 10", p0_ready, p1_ready); end
        step();
        n_cmp++; if (res_port !== 1'b0 || res_s !== 32'd0 || gnt_cnt0 !== 16'd3) begin
            n_bad++;
            $display("FAIL bp_next got port=%b s=%h cnt0=%0d want 0 0 3", res_port, res_s,
                     gnt_cnt0); end
    endtask

    task automatic test_back_to_back();
        p0_valid = 1'b0;
        p1_valid = 1'b1; p1_a = 32'd0; p1_b = 32'd0; p1_aluop = 4'b1100;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (p1_ready !== 1'b1) begin n_bad++;
                $display("FAIL b2b_ready[%0d] got %b want 1", i, p1_ready); end
            step();
            n_cmp++; if (res_valid !== 1'b1 || res_s !== 32'hFFFF_FFFF || res_port !== 1'b1)
            begin n_bad++;
                $display("FAIL b2b_res[%0d] got v=%b s=%h port=%b want 1 ffffffff 1", i,
                         res_valid, res_s, res_port); end
        end
        n_cmp++; if (gnt_cnt1 !== 16'd7) begin n_bad++;
            $display("FAIL b2b_cnt got %0d want 7", gnt_cnt1); end
    endtask

    task automatic test_reset_midflight();
        p1_valid = 1'b0;
        p0_valid = 1'b1; p0_a = 32'd1; p0_b = 32'd1; p0_aluop = 4'b0010;
        reset = 1'b1;
        step();
        reset = 1'b0;
        p0_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || res_s !== 32'd0) begin n_bad++;
            $display("FAIL mid_res got v=%b s=%h want 0 0", res_valid, res_s); end
        n_cmp++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin n_bad++;
            $display("FAIL mid_cnt got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1); end
        p0_valid = 1'b1; p1_valid = 1'b1; p1_aluop = 4'b0001;
        #1;
        n_cmp++; if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin n_bad++;
            $display("FAIL mid_first got %b%b want 10", p0_ready, p1_ready); end
        step();
        p0_valid = 1'b0; p1_valid = 1'b0;
        n_cmp++; if (res_port !== 1'b0 || res_s !== 32'd2) begin n_bad++;
            $display("FAIL mid_port got port=%b s=%h want 0 2", res_port, res_s); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        reset = 1'b1;
        step();
        reset = 1'b0;
        p1_valid = 1'b0;
        p0_valid = 1'b1; p0_a = 32'd3; p0_b = 32'd4; p0_aluop = 4'b0000;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (s_cnt0 !== exp_cnt[i]) begin n_bad++;
                $display("FAIL sat_cnt[%0d] got %0d want %0d", i, s_cnt0, exp_cnt[i]); end
            n_cmp++; if (s_res_valid !== 1'b1 || s_res_zero !== 1'b1) begin n_bad++;
                $display("FAIL sat_res[%0d] got v=%b z=%b want 1 1", i, s_res_valid,
                         s_res_zero); end
        end
        p0_valid = 1'b0;
        step();
        n_cmp++; if (res_valid !== 1'b0 || res_s !== 32'd0) begin n_bad++;
            $display("FAIL drain got v=%b s=%h want 0 0", res_valid, res_s); end
    endtask

    initial begin
        reset = 1'b1;
        p0_valid = 1'b0; p1_valid = 1'b0; res_ready = 1'b0;
        p0_a = '0; p0_b = '0; p1_a = '0; p1_b = '0;
        p0_aluop = '0; p1_aluop = '0;
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
